// File: rtl/binary_round_sched.sv
// Purpose: session scheduler for the binary-number game (rounds, timing, score, lives, high score).
// Latency: one Clk from input pulse to registered output; ISSUE is a single-cycle state.
// Backpressure: none; single-cycle pulses are consumed in the cycle they arrive or ignored.
//
// Ports:
//   Clk, Reset (async, active-high)
//   Tick      - time-base enable; counts TimeLeft down while waiting for an answer
//   Start     - begin a new game from IDLE or OVER
//   Abort     - end the running game immediately
//   Submit    - player committed an answer; Correct is the datapath compare flag
//   NewNumReq - one-cycle pulse per round asking the datapath for a new number
//   TimeLeft  - Tick periods remaining in the current round
//   Lives, Score, HighScore, GameOver, StateOH ({OVER, WAIT, ISSUE, IDLE})
module binary_round_sched #(
    parameter int ROUND_TIME    = 10,
    parameter int MIN_TIME      = 3,
    parameter int SPEEDUP_EVERY = 4,
    parameter int START_LIVES   = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Start,
    input  logic       Abort,
    input  logic       Submit,
    input  logic       Correct,
    output logic       NewNumReq,
    output logic [7:0] TimeLeft,
    output logic [2:0] Lives,
    output logic [7:0] Score,
    output logic [7:0] HighScore,
    output logic       GameOver,
    output logic [3:0] StateOH
);

    // State register is one-hot so it can drive StateOH directly.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        OVER  = 4'b1000
    } state_t;

    localparam logic [7:0] ROUND_T   = 8'(ROUND_TIME);
    localparam logic [7:0] MIN_T     = 8'(MIN_TIME);
    localparam logic [3:0] STREAK_HI = 4'(SPEEDUP_EVERY - 1);
    localparam logic [2:0] LIVES_0   = 3'(START_LIVES);

    state_t     state;
    logic [7:0] limit;
    logic [3:0] streak;
    logic       miss;

    assign StateOH = state;

    // A wrong answer, or the last Tick of the round with no answer this cycle.
    // Submit takes priority over a Tick arriving in the same cycle.
    assign miss = (Submit && !Correct) || (!Submit && Tick && (TimeLeft == 8'd1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            NewNumReq <= 1'b0;
            TimeLeft  <= 8'd0;
            Lives     <= 3'd0;
            Score     <= 8'd0;
            HighScore <= 8'd0;
            GameOver  <= 1'b0;
            limit     <= ROUND_T;
            streak    <= 4'd0;
        end else begin
            NewNumReq <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (Start) begin
                        state     <= ISSUE;
                        NewNumReq <= 1'b1;
                        GameOver  <= 1'b0;
                        Lives     <= LIVES_0;
                        Score     <= 8'd0;
                        limit     <= ROUND_T;
                        streak    <= 4'd0;
                    end
                end
                ISSUE: begin
                    TimeLeft <= limit;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (Abort) begin
                        state    <= OVER;
                        GameOver <= 1'b1;
                        if (Score > HighScore) HighScore <= Score;
                    end else if (Submit && Correct) begin
                        if (Score != 8'hFF) Score <= Score + 8'd1;
                        if (streak == STREAK_HI) begin
                            streak <= 4'd0;
                            // Shrink the round limit, clamped at the floor.
                            limit  <= (limit > MIN_T) ? limit - 8'd1 : MIN_T;
                        end else begin
                            streak <= streak + 4'd1;
                        end
                        state     <= ISSUE;
                        NewNumReq <= 1'b1;
                    end else if (miss) begin
                        streak <= 4'd0;
                        if (!Submit) TimeLeft <= 8'd0;
                        if (Lives == 3'd1) begin
                            Lives    <= 3'd0;
                            state    <= OVER;
                            GameOver <= 1'b1;
                            if (Score > HighScore) HighScore <= Score;
                        end else begin
                            Lives     <= Lives - 3'd1;
                            state     <= ISSUE;
                            NewNumReq <= 1'b1;
                        end
                    end else if (Tick && (TimeLeft != 8'd0)) begin
                        TimeLeft <= TimeLeft - 8'd1;
                    end
                end
                default: begin
                    // Corrupted state: recover to a clean IDLE but keep the high score.
                    state    <= IDLE;
                    TimeLeft <= 8'd0;
                    Lives    <= 3'd0;
                    Score    <= 8'd0;
                    GameOver <= 1'b0;
                    limit    <= ROUND_T;
                    streak   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/binary_round_sched.md
Name: binary_round_sched

Overview:
- Session scheduler for the binary-number game datapath. Sequences timed play rounds: requests a new random number, times the player's answer against a per-round limit, and judges the result from the datapath's compare flag.
- Tracks score, lives, a shrinking time limit, and a persistent high score.
- Sits between the menu FSM (Start/Abort) and the number generator/comparator (NewNumReq/Correct).

Parameters:
- ROUND_TIME, 10: initial per-round time limit in Tick periods; legal 1..255.
- MIN_TIME, 3: floor for the shrinking limit; legal 1..ROUND_TIME.
- SPEEDUP_EVERY, 4: correct answers in a row needed before the limit drops by 1; legal 1..15.
- START_LIVES, 3: lives at game start; legal 1..7.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Tick  in  1  single-cycle time-base pulse (e.g. 1 Hz enable)
- Start  in  1  single-cycle pulse; begin a new game
- Abort  in  1  single-cycle pulse; end the game immediately
- Submit  in  1  single-cycle pulse; player committed an answer
- Correct  in  1  datapath compare flag; valid whenever Submit=1
- NewNumReq  out  1  single-cycle pulse; datapath latches a new random number
- TimeLeft  out  8  Tick periods remaining in the current round
- Lives  out  3  remaining lives
- Score  out  8  correct answers this game, saturating
- HighScore  out  8  best Score since Reset
- GameOver  out  1  high while in OVER
- StateOH  out  4  one-hot {OVER, WAIT, ISSUE, IDLE}

Behaviour:
- Reset (any time, including mid-game):
  - state=IDLE, StateOH=4'b0001.
  - NewNumReq=0, TimeLeft=0, Lives=0, Score=0, HighScore=0, GameOver=0.
  - Internal limit=ROUND_TIME, streak=0.
- All registers are updated on posedge Clk only; outputs are registered.
- IDLE:
  - Start → ISSUE; load Lives=START_LIVES, Score=0, limit=ROUND_TIME, streak=0.
  - All other inputs are ignored.
- ISSUE (lasts exactly one cycle):
  - NewNumReq=1 during this cycle; TimeLeft<=limit.
  - Always → WAIT.
  - Tick, Submit, Abort and Start are ignored in this cycle.
- WAIT, evaluated in priority order:
  1. Abort → OVER.
  2. Submit && Correct:
     - Score<=Score+1, saturating at 255.
     - If streak==SPEEDUP_EVERY-1: streak<=0 and limit<=max(limit-1, MIN_TIME). Otherwise streak<=streak+1.
     - → ISSUE.
  3. Submit && !Correct → MISS action.
  4. Tick && TimeLeft==1 → MISS action (timeout); TimeLeft<=0.
  5. Tick otherwise → TimeLeft<=TimeLeft-1.
  - Start is ignored in WAIT.
  - Submit together with Tick in the same cycle: Submit wins and the Tick is dropped.
- MISS action (not a state):
  - streak<=0.
  - If Lives==1: Lives<=0 → OVER.
  - Else: Lives<=Lives-1 → ISSUE.
- Entering OVER (by any path):
  - If Score>HighScore: HighScore<=Score, in the same cycle as the transition.
  - Score, Lives and TimeLeft hold their final values.
- OVER:
  - GameOver=1.
  - Start → ISSUE with the same loads as IDLE+Start (the IDLE state is skipped).
  - Other inputs are ignored.
- The limit never goes below MIN_TIME and never changes outside WAIT scoring.
- HighScore is cleared only by Reset. An equal score does not count as an update (no observable change).
- NewNumReq is never asserted outside ISSUE; there is exactly one pulse per round.
- Undefined or illegal state encoding → IDLE next cycle, with outputs as after reset except HighScore, which is kept.

Test Plan:
- Reset, Start, then Submit+Correct 8 times (defaults) → 9 NewNumReq pulses; Score=8; limit is 9 after the 4th correct and 8 after the 8th; TimeLeft=8 in the following WAIT.
- Start, then no Submit and 10 Ticks → on the 10th Tick Lives goes 3→2, TimeLeft reaches 0, a new ISSUE follows, then TimeLeft=10.
- Start, then Submit+!Correct 3 times → Lives goes 3,2,1,0; GameOver=1; StateOH=4'b1000; HighScore=0.
- Score 5 then Abort (HighScore→5); Start, Score 3, then Abort → HighScore stays 5; Score resets to 0 on the second Start.
- Submit+Correct and Tick in the same cycle with TimeLeft=1 → Score increments, no life is lost, next state is ISSUE.
- Assert Reset mid-WAIT with Score=7 and HighScore=9 → all outputs 0, HighScore=0, StateOH=4'b0001; a subsequent Start behaves normally.
